// File: rtl/gpio_out_ctrl.sv
// GPIO output controller: owns the pin data/enable registers and runs
// WRITE/SET/CLR/PULSE commands from a valid/ready command port.
module gpio_out_ctrl #(
    parameter int NPINS = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [NPINS-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             oe_wr,
    input  logic [NPINS-1:0] oe_data,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             pulse_busy,
    output logic             pulse_done
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_PULSE = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [NPINS-1:0] mask, mask_nxt;
    logic [NPINS-1:0] out_nxt, oe_nxt;
    logic             done_nxt;

    assign cmd_ready  = (state == S_IDLE) && !reset;
    assign pulse_busy = (state == S_PULSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mask       <= '0;
            gpio_out   <= '0;
            gpio_oe    <= '0;
            pulse_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mask       <= mask_nxt;
            gpio_out   <= out_nxt;
            gpio_oe    <= oe_nxt;
            pulse_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        out_nxt   = gpio_out;
        oe_nxt    = gpio_oe;
        done_nxt  = 1'b0;

        if (oe_wr)
            oe_nxt = oe_data;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: out_nxt = cmd_data;
                        OP_SET:   out_nxt = gpio_out | cmd_data;
                        OP_CLR:   out_nxt = gpio_out & ~cmd_data;
                        OP_PULSE: begin
                            // Zero-length pulse only produces the done strobe.
                            if (cmd_len == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                out_nxt   = gpio_out ^ cmd_data;
                                mask_nxt  = cmd_data;
                                cnt_nxt   = cmd_len;
                                state_nxt = S_PULSE;
                            end
                        end
                        default: out_nxt = gpio_out;
                    endcase
                end
            end
            S_PULSE: begin
                // Restore on terminal count so the pins stay inverted exactly N cycles.
                if (cnt == CNT_W'(1)) begin
                    out_nxt   = gpio_out ^ mask;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpio_out_ctrl.sv
// Scoreboard bench for gpio_out_ctrl: stimulus pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_gpio_out_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] cmd_len;
    logic        oe_wr;
    logic [15:0] oe_data;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        pulse_busy;
    logic        pulse_done;

    gpio_out_ctrl #(.NPINS(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .oe_wr      (oe_wr),
        .oe_data    (oe_data),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .pulse_busy (pulse_busy),
        .pulse_done (pulse_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [15:0] oe;
        logic        busy;
        logic        done;
        logic        ready;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [1:0] WR = 2'b00, ST = 2'b01, CL = 2'b10, PU = 2'b11;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s.%s: got %h expected %h at %0t", nm, fld, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            chk(e.name, "gpio_out",   gpio_out,          e.out);
            chk(e.name, "gpio_oe",    gpio_oe,           e.oe);
            chk(e.name, "pulse_busy", {15'd0, pulse_busy}, {15'd0, e.busy});
            chk(e.name, "pulse_done", {15'd0, pulse_done}, {15'd0, e.done});
            chk(e.name, "cmd_ready",  {15'd0, cmd_ready},  {15'd0, e.ready});
        end
    end

    // Drive one cycle of inputs; expected values are what the monitor sees after the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [15:0] d,
                        input logic [15:0] len, input logic ow, input logic [15:0] od,
                        input logic r, input logic [15:0] eo, input logic [15:0] eoe,
                        input logic eb, input logic ed, input logic er, input string nm);
        exp_t e;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = len;
        oe_wr     = ow;
        oe_data   = od;
        reset     = r;
        @(posedge clk);
        e.name = nm; e.out = eo; e.oe = eoe; e.busy = eb; e.done = ed; e.ready = er;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] eo, input logic [15:0] eoe,
                        input logic eb, input logic ed, input logic er, input string nm);
        step(1'b0, WR, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, eo, eoe, eb, ed, er, nm);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = WR; cmd_data = '0; cmd_len = '0;
        oe_wr = 1'b0; oe_data = '0;
        @(negedge clk); #1;

        step(0, WR, 16'h0, 16'h0, 0, 16'h0, 1, 16'h0000, 16'h0000, 0, 0, 0, "reset");
        idle(16'h0000, 16'h0000, 0, 0, 1, "post_reset");

        // WRITE
        step(1, WR, 16'hA5A5, 16'h0, 0, 16'h0, 0, 16'hA5A5, 16'h0000, 0, 0, 1, "write_a5a5");
        idle(16'hA5A5, 16'h0000, 0, 0, 1, "write_hold");

        // SET then CLR back to back
        step(1, WR, 16'h0000, 16'h0, 0, 16'h0, 0, 16'h0000, 16'h0000, 0, 0, 1, "write_zero");
        step(1, ST, 16'h000F, 16'h0, 0, 16'h0, 0, 16'h000F, 16'h0000, 0, 0, 1, "set_000f");
        step(1, CL, 16'h0005, 16'h0, 0, 16'h0, 0, 16'h000A, 16'h0000, 0, 0, 1, "clr_0005");
        idle(16'h000A, 16'h0000, 0, 0, 1, "setclr_hold");

        // PULSE len 3 with a WRITE held pending, accepted on the done cycle
        step(1, WR, 16'h0000, 16'h0, 0, 16'h0, 0, 16'h0000, 16'h0000, 0, 0, 1, "write_zero2");
        step(1, PU, 16'h4000, 16'd3, 0, 16'h0, 0, 16'h4000, 16'h0000, 1, 0, 0, "pulse3_c1");
        step(1, WR, 16'h8000, 16'd0, 0, 16'h0, 0, 16'h4000, 16'h0000, 1, 0, 0, "pulse3_c2");
        step(1, WR, 16'h8000, 16'd0, 0, 16'h0, 0, 16'h4000, 16'h0000, 1, 0, 0, "pulse3_c3");
        step(1, WR, 16'h8000, 16'd0, 0, 16'h0, 0, 16'h0000, 16'h0000, 0, 1, 1, "pulse3_done");
        step(1, WR, 16'h8000, 16'd0, 0, 16'h0, 0, 16'h8000, 16'h0000, 0, 0, 1, "accept_on_done");
        idle(16'h8000, 16'h0000, 0, 0, 1, "after_overlap");

        // PULSE len 0
        step(1, PU, 16'hFFFF, 16'd0, 0, 16'h0, 0, 16'h8000, 16'h0000, 0, 1, 1, "pulse0_done");
        idle(16'h8000, 16'h0000, 0, 0, 1, "pulse0_after");

        // oe_wr in the middle of a pulse
        step(1, PU, 16'h0001, 16'd2, 0, 16'h0, 0, 16'h8001, 16'h0000, 1, 0, 0, "pulse2_c1");
        step(0, WR, 16'h0000, 16'd0, 1, 16'hFFFF, 0, 16'h8001, 16'hFFFF, 1, 0, 0, "oe_mid_pulse");
        idle(16'h8000, 16'hFFFF, 0, 1, 1, "pulse2_done");
        idle(16'h8000, 16'hFFFF, 0, 0, 1, "pulse2_after");

        // Zero-mask pulse: timing only
        step(1, PU, 16'h0000, 16'd2, 0, 16'h0, 0, 16'h8000, 16'hFFFF, 1, 0, 0, "pulse_nomask_c1");
        idle(16'h8000, 16'hFFFF, 1, 0, 0, "pulse_nomask_c2");
        idle(16'h8000, 16'hFFFF, 0, 1, 1, "pulse_nomask_done");

        // Reset mid-pulse
        step(1, WR, 16'h0001, 16'h0, 0, 16'h0, 0, 16'h0001, 16'hFFFF, 0, 0, 1, "write_0001");
        step(1, PU, 16'h8001, 16'd10, 0, 16'h0, 0, 16'h8000, 16'hFFFF, 1, 0, 0, "pulse10_c1");
        idle(16'h8000, 16'hFFFF, 1, 0, 0, "pulse10_c2");
        idle(16'h8000, 16'hFFFF, 1, 0, 0, "pulse10_c3");
        idle(16'h8000, 16'hFFFF, 1, 0, 0, "pulse10_c4");
        step(0, WR, 16'h0, 16'h0, 0, 16'h0, 1, 16'h0000, 16'h0000, 0, 0, 0, "reset_mid_pulse");
        idle(16'h0000, 16'h0000, 0, 0, 1, "post_reset2");
        for (int i = 0; i < 12; i++)
            idle(16'h0000, 16'h0000, 0, 0, 1, "no_done_after_reset");

        // Maximum-length pulse
        step(1, PU, 16'h0001, 16'hFFFF, 0, 16'h0, 0, 16'h0001, 16'h0000, 1, 0, 0, "pulse_max_c1");
        for (int i = 0; i < 65534; i++)
            idle(16'h0001, 16'h0000, 1, 0, 0, "pulse_max_hold");
        idle(16'h0000, 16'h0000, 0, 1, 1, "pulse_max_done");
        idle(16'h0000, 16'h0000, 0, 0, 1, "pulse_max_after");

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
